// File: rtl/serial_word_comparator.sv
// Serial magnitude comparator: one DIGIT_W-bit digit of A and B per accepted beat,
// MSB-first or LSB-first per word, single-cycle registered result pulse per word.
module serial_word_comparator #(
  parameter int DIGIT_W    = 1,
  parameter int WORD_BEATS = 8,
  parameter int SIGNED     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               msb_first,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               busy,
  output logic               res_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b
);

  localparam int CW = (WORD_BEATS > 2) ? $clog2(WORD_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORD_BEATS - 1);

  typedef enum logic [1:0] {
    st_eq,
    st_lt,
    st_gt
  } state_t;

  // Flipping the top bit maps two's-complement order onto unsigned order.
  function automatic logic [DIGIT_W-1:0] sign_adjust(input logic [DIGIT_W-1:0] d,
                                                     input logic              en);
    logic [DIGIT_W-1:0] r;
    r = d;
    if (en) r[DIGIT_W-1] = ~d[DIGIT_W-1];
    return r;
  endfunction

  function automatic state_t next_state(input state_t cur, input logic lt,
                                        input logic gt, input logic msb);
    state_t nx;
    nx = cur;
    if (msb) begin
      if (cur == st_eq) begin
        if (lt)      nx = st_lt;
        else if (gt) nx = st_gt;
      end
    end else begin
      if (lt)      nx = st_lt;
      else if (gt) nx = st_gt;
    end
    return nx;
  endfunction

  logic [CW-1:0]      cnt_q, cnt_d;
  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               busy_q, res_valid_q, lt_q, eq_q, gt_q;

  logic               first_beat, last_beat, mode_eff, sign_beat;
  logic [DIGIT_W-1:0] a_c, b_c;
  logic               dlt, dgt, done;
  state_t             beat_state;

  always_comb begin
    first_beat = (cnt_q == '0);
    last_beat  = (cnt_q == LAST_BEAT);
    // Beat 0 follows the live msb_first; the register only governs later beats.
    mode_eff   = first_beat ? msb_first : mode_q;
    sign_beat  = mode_eff ? first_beat : last_beat;
    a_c        = sign_adjust(a, (SIGNED != 0) && sign_beat);
    b_c        = sign_adjust(b, (SIGNED != 0) && sign_beat);
    dlt        = (a_c < b_c);
    dgt        = (a_c > b_c);
    beat_state = next_state(first_beat ? st_eq : state_q, dlt, dgt, mode_eff);
    done       = in_valid && !clear && last_beat;

    cnt_d   = cnt_q;
    state_d = state_q;
    mode_d  = mode_q;
    if (clear) begin
      cnt_d   = '0;
      state_d = st_eq;
    end else if (in_valid) begin
      cnt_d   = last_beat ? '0 : cnt_q + CW'(1);
      state_d = beat_state;
      if (first_beat) mode_d = msb_first;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      state_q     <= st_eq;
      mode_q      <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      busy_q      <= (cnt_d != '0);
      res_valid_q <= done;
      lt_q        <= done && (beat_state == st_lt);
      eq_q        <= done && (beat_state == st_eq);
      gt_q        <= done && (beat_state == st_gt);
    end
  end

  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign a_less_b    = lt_q;
  assign a_eq_b      = eq_q;
  assign a_greater_b = gt_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Bench for serial_word_comparator: an unsigned 1x8 instance and a signed 4x2 instance,
// expected flags queued per word and checked when res_valid appears.
module tb_serial_word_comparator;

  logic       clk, rst;
  logic       u_clear, u_iv, u_msb;
  logic [0:0] u_a, u_b;
  logic       u_busy, u_rv, u_lt, u_eq, u_gt;
  logic       s_clear, s_iv, s_msb;
  logic [3:0] s_a, s_b;
  logic       s_busy, s_rv, s_lt, s_eq, s_gt;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] q_u[$];
  logic [2:0] q_s[$];
  logic [2:0] e_u, e_s;
  bit         mon_en = 0;

  serial_word_comparator #(.DIGIT_W(1), .WORD_BEATS(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .clear(u_clear), .in_valid(u_iv), .msb_first(u_msb),
    .a(u_a), .b(u_b), .busy(u_busy), .res_valid(u_rv),
    .a_less_b(u_lt), .a_eq_b(u_eq), .a_greater_b(u_gt)
  );

  serial_word_comparator #(.DIGIT_W(4), .WORD_BEATS(2), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_iv), .msb_first(s_msb),
    .a(s_a), .b(s_b), .busy(s_busy), .res_valid(s_rv),
    .a_less_b(s_lt), .a_eq_b(s_eq), .a_greater_b(s_gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_u(input logic [7:0] A, input logic [7:0] B);
    return {A < B, A == B, A > B};
  endfunction

  function automatic logic [2:0] exp_s(input logic [7:0] A, input logic [7:0] B);
    return {$signed(A) < $signed(B), A == B, $signed(A) > $signed(B)};
  endfunction

  // Scoreboard monitors
  always begin
    @(posedge clk); #1;
    if (mon_en) begin
      n_tests++;
      if (u_rv === 1'b1) begin
        if (q_u.size() == 0) begin
          n_fail++;
          $display("FAIL u_unexpected_result: res_valid=1 flags=%b, no word pending", {u_lt, u_eq, u_gt});
        end else begin
          e_u = q_u.pop_front();
          if ({u_lt, u_eq, u_gt} !== e_u) begin
            n_fail++;
            $display("FAIL u_result_flags: got lt/eq/gt=%b want %b", {u_lt, u_eq, u_gt}, e_u);
          end
        end
      end else if ({u_rv, u_lt, u_eq, u_gt} !== 4'b0000) begin
        n_fail++;
        $display("FAIL u_idle_flags: got rv/lt/eq/gt=%b want 0000", {u_rv, u_lt, u_eq, u_gt});
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (mon_en) begin
      n_tests++;
      if (s_rv === 1'b1) begin
        if (q_s.size() == 0) begin
          n_fail++;
          $display("FAIL s_unexpected_result: res_valid=1 flags=%b, no word pending", {s_lt, s_eq, s_gt});
        end else begin
          e_s = q_s.pop_front();
          if ({s_lt, s_eq, s_gt} !== e_s) begin
            n_fail++;
            $display("FAIL s_result_flags: got lt/eq/gt=%b want %b", {s_lt, s_eq, s_gt}, e_s);
          end
        end
      end else if ({s_rv, s_lt, s_eq, s_gt} !== 4'b0000) begin
        n_fail++;
        $display("FAIL s_idle_flags: got rv/lt/eq/gt=%b want 0000", {s_rv, s_lt, s_eq, s_gt});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    u_iv = 1'b0;
    s_iv = 1'b0;
    repeat (n) tick();
  endtask

  // msb_first is driven inverted on non-first beats; the DUT must ignore it there.
  task automatic drive_beat(input bit sel, input logic [7:0] A, input logic [7:0] B,
                            input int i, input bit msb);
    int idx;
    bit hi;
    if (!sel) begin
      idx   = msb ? 7 - i : i;
      u_iv  = 1'b1;
      u_a   = A[idx];
      u_b   = B[idx];
      u_msb = (i == 0) ? msb : ~msb;
    end else begin
      hi    = msb ? (i == 0) : (i == 1);
      s_iv  = 1'b1;
      s_a   = hi ? A[7:4] : A[3:0];
      s_b   = hi ? B[7:4] : B[3:0];
      s_msb = (i == 0) ? msb : ~msb;
    end
    tick();
    u_iv = 1'b0;
    s_iv = 1'b0;
  endtask

  task automatic push_exp(input bit sel, input logic [7:0] A, input logic [7:0] B);
    if (!sel) q_u.push_back(exp_u(A, B));
    else      q_s.push_back(exp_s(A, B));
  endtask

  task automatic drive_word(input bit sel, input logic [7:0] A, input logic [7:0] B, input bit msb);
    int n;
    n = sel ? 2 : 8;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) push_exp(sel, A, B);
      drive_beat(sel, A, B, i, msb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({u_busy, u_rv, u_lt, u_eq, u_gt} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_u: got busy/rv/lt/eq/gt=%b want 00000", {u_busy, u_rv, u_lt, u_eq, u_gt});
    end
    n_tests++;
    if ({s_busy, s_rv, s_lt, s_eq, s_gt} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_s: got busy/rv/lt/eq/gt=%b want 00000", {s_busy, s_rv, s_lt, s_eq, s_gt});
    end
    rst = 1'b0;
    mon_en = 1;
  endtask

  task automatic test_msb_unsigned();
    drive_word(0, 8'h5A, 8'h5B, 1'b1);
    n_tests++;
    if ({u_rv, u_lt, u_eq, u_gt} !== 4'b1100) begin
      n_fail++;
      $display("FAIL msb_latency: got rv/lt/eq/gt=%b want 1100", {u_rv, u_lt, u_eq, u_gt});
    end
    tick();
    n_tests++;
    if (u_rv !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_pulse_width: got res_valid=%b want 0", u_rv);
    end
    drive_word(0, 8'hA5, 8'h5A, 1'b1);
    drive_word(0, 8'h3C, 8'h3C, 1'b1);
    drive_word(0, 8'h01, 8'h02, 1'b1);
    idle(2);
  endtask

  task automatic test_lsb_back_to_back();
    drive_word(0, 8'h5A, 8'h5B, 1'b0);
    n_tests++;
    if ({u_rv, u_lt} !== 2'b11) begin
      n_fail++;
      $display("FAIL lsb_first_pulse: got rv/lt=%b want 11", {u_rv, u_lt});
    end
    drive_word(0, 8'hC3, 8'hC3, 1'b0);
    n_tests++;
    if ({u_rv, u_eq} !== 2'b11) begin
      n_fail++;
      $display("FAIL lsb_second_pulse: got rv/eq=%b want 11", {u_rv, u_eq});
    end
    drive_word(0, 8'h01, 8'h02, 1'b0);
    drive_word(0, 8'h80, 8'h7F, 1'b0);
    idle(2);
  endtask

  task automatic test_signed();
    drive_word(1, 8'h80, 8'h7F, 1'b1);
    n_tests++;
    if ({s_rv, s_lt} !== 2'b11) begin
      n_fail++;
      $display("FAIL signed_msb: got rv/lt=%b want 11", {s_rv, s_lt});
    end
    drive_word(1, 8'hFF, 8'h01, 1'b0);
    drive_word(1, 8'h7F, 8'h80, 1'b0);
    drive_word(1, 8'hF0, 8'hF0, 1'b1);
    drive_word(1, 8'h01, 8'hFF, 1'b1);
    idle(2);
  endtask

  task automatic test_gaps();
    n_tests++;
    if (u_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_busy_before: got %b want 0", u_busy);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          n_tests++;
          if (u_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_busy_hold: cycle %0d got %b want 1", g, u_busy);
          end
        end
      end
      if (i == 7) push_exp(0, 8'h10, 8'h0F);
      drive_beat(0, 8'h10, 8'h0F, i, 1'b1);
      n_tests++;
      if (u_busy !== (i != 7)) begin
        n_fail++;
        $display("FAIL gap_busy_beat%0d: got %b want %b", i, u_busy, (i != 7));
      end
    end
    n_tests++;
    if ({u_rv, u_gt} !== 2'b11) begin
      n_fail++;
      $display("FAIL gap_result: got rv/gt=%b want 11", {u_rv, u_gt});
    end
    idle(2);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) drive_beat(0, 8'h3C, 8'h00, i, 1'b1);
    u_clear = 1'b1;
    u_iv    = 1'b1;
    u_a     = 1'b1;
    u_b     = 1'b0;
    tick();
    u_clear = 1'b0;
    u_iv    = 1'b0;
    n_tests++;
    if ({u_busy, u_rv} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_state: got busy/rv=%b want 00", {u_busy, u_rv});
    end
    drive_word(0, 8'h00, 8'h00, 1'b1);
    n_tests++;
    if ({u_rv, u_eq} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_next_word: got rv/eq=%b want 11", {u_rv, u_eq});
    end
    idle(2);
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 3; i++) drive_beat(0, 8'hFF, 8'h00, i, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({u_busy, u_rv, u_lt, u_eq, u_gt} !== 5'b0) begin
      n_fail++;
      $display("FAIL midword_reset: got busy/rv/lt/eq/gt=%b want 00000", {u_busy, u_rv, u_lt, u_eq, u_gt});
    end
    drive_word(0, 8'h80, 8'h7F, 1'b0);
    drive_word(0, 8'h01, 8'h80, 1'b1);
    idle(3);
  endtask

  initial begin
    rst     = 1'b1;
    u_clear = 1'b0; u_iv = 1'b0; u_msb = 1'b1; u_a = '0; u_b = '0;
    s_clear = 1'b0; s_iv = 1'b0; s_msb = 1'b1; s_a = '0; s_b = '0;
    test_reset();
    test_msb_unsigned();
    test_lsb_back_to_back();
    test_signed();
    test_gaps();
    test_abort();
    test_reset_midword();
    n_tests++;
    if (q_u.size() != 0 || q_s.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: got %0d/%0d words without result want 0/0", q_u.size(), q_s.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
